// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion scheduler and its double-dabble core.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StResp
    } state_t;

    localparam int unsigned BCD_DIGITS = 4;
    localparam int unsigned BIN_W      = 16;
    localparam logic [15:0] MAX_DEC    = 16'd9999;
    localparam logic [15:0] BCD_SAT    = 16'h9999;

    // One double-dabble iteration: add 3 to every digit above 4, then shift in the next bit.
    function automatic logic [4*BCD_DIGITS-1:0] dabble_step(
        input logic [4*BCD_DIGITS-1:0] bcd_in,
        input logic                    bit_in
    );
        logic [4*BCD_DIGITS-1:0] adj;
        adj = bcd_in;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (bcd_in[4*d +: 4] > 4'd4) begin
                adj[4*d +: 4] = bcd_in[4*d +: 4] + 4'd3;
            end
        end
        return {adj[4*BCD_DIGITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Sequential 16-bit binary-to-BCD converter, one double-dabble iteration per clock.
module bcd_dabble_core
    import bcd_pkg::*;
(
    input  logic             clock,
    input  logic             a_rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam logic [4:0] LAST_ITER = 5'(BIN_W);

    logic [BIN_W-1:0] shift_q;
    logic [15:0]      bcd_q;
    logic [4:0]       cnt_q;
    logic             run_q;

    // The start edge performs the first iteration directly from bin, so the result is ready
    // after 16 edges and done is visible in the 16th cycle after start.
    always_ff @(posedge clock or posedge a_rst) begin
        if (a_rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (!run_q) begin
            if (start) begin
                bcd_q   <= dabble_step('0, bin[BIN_W-1]);
                shift_q <= {bin[BIN_W-2:0], 1'b0};
                cnt_q   <= 5'd1;
                run_q   <= 1'b1;
            end
        end else if (cnt_q == LAST_ITER) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            bcd_q   <= dabble_step(bcd_q, shift_q[BIN_W-1]);
            shift_q <= {shift_q[BIN_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 5'd1;
        end
    end

    assign done = run_q && (cnt_q == LAST_ITER);
    assign bcd  = bcd_q;

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one double-dabble converter between N_REQ requesters.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   a_rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [BIN_W*N_REQ-1:0] req_bin,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [15:0]            rsp_bcd,
    output logic                   rsp_ovf,
    output logic                   busy
);

    state_t          state_q;
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] rsp_id_q;
    logic [15:0]     rsp_bcd_q;
    logic            rsp_ovf_q;
    logic            rsp_valid_q;
    logic            busy_q;

    logic             any_req;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  nxt_ptr;
    logic [BIN_W-1:0] sel_bin;
    logic             in_range;
    logic             core_start;
    logic             core_done;
    logic [15:0]      core_bcd;

    // Round-robin search starting at ptr_q; the first valid requester wins.
    always_comb begin
        any_req = 1'b0;
        win_id  = '0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!any_req && req_valid[cand]) begin
                any_req = 1'b1;
                win_id  = cand;
            end
        end
    end

    always_comb begin
        sel_bin    = req_bin[BIN_W*32'(win_id) +: BIN_W];
        in_range   = (sel_bin <= MAX_DEC);
        nxt_ptr    = (32'(win_id) == N_REQ - 1) ? '0 : win_id + ID_W'(1);
        core_start = (state_q == StIdle) && any_req && in_range;
        req_ready  = '0;
        // Reset is folded in so the grant is also forced low while reset is held.
        if ((state_q == StIdle) && any_req && !a_rst) begin
            req_ready[win_id] = 1'b1;
        end
    end

    bcd_dabble_core u_core (
        .clock (clock),
        .a_rst (a_rst),
        .start (core_start),
        .bin   (sel_bin),
        .done  (core_done),
        .bcd   (core_bcd)
    );

    always_ff @(posedge clock or posedge a_rst) begin
        if (a_rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            rsp_bcd_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        rsp_id_q <= win_id;
                        ptr_q    <= nxt_ptr;
                        busy_q   <= 1'b1;
                        if (in_range) begin
                            state_q <= StConv;
                        end else begin
                            rsp_bcd_q   <= BCD_SAT;
                            rsp_ovf_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end
                end
                StConv: begin
                    if (core_done) begin
                        rsp_bcd_q   <= core_bcd;
                        rsp_ovf_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_bcd   = rsp_bcd_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: expectations queued at grant, checked at each handshake.
module tb_bcd_conv_sched;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;

    logic        clock = 1'b0;
    logic        a_rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [63:0] req_bin = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_bcd;
    logic        rsp_ovf;
    logic        busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    bcd_conv_sched #(
        .N_REQ (4),
        .ID_W  (2)
    ) dut (
        .clock     (clock),
        .a_rst     (a_rst),
        .req_valid (req_valid),
        .req_bin   (req_bin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every response handshake pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (rsp_valid && rsp_ready && !a_rst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", {14'd0, rsp_id, rsp_bcd}, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_bcd", 32'(rsp_bcd), 32'(e.bcd));
                    check("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic wait_grant(output int idx, output int g);
        bit ok;
        ok  = 1'b0;
        idx = -1;
        g   = 0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clock);
            if (|(req_valid & req_ready)) begin
                ok = 1'b1;
                g  = cyc;
                for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clock);
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clock);
            if (!busy && !rsp_valid) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_single(input int i, input logic [15:0] bin, input logic [15:0] ebcd,
                             input logic eovf, input int lat);
        int  idx;
        int  g;
        bit  ok;
        @(posedge clock);
        #1;
        req_bin[16*i +: 16] = bin;
        req_valid[i] = 1'b1;
        wait_grant(idx, g);
        check("single_grant", 32'(idx), 32'(i));
        exp_q.push_back('{id: 2'(i), bcd: ebcd, ovf: eovf});
        @(posedge clock);
        #1;
        req_valid[i] = 1'b0;
        wait_rsp(ok);
        if (ok) check("latency", 32'(cyc - g), 32'(lat));
        wait_idle();
    endtask

    initial begin
        int          idx;
        int          g;
        int          last;
        int          extra;
        bit          ok;
        int          order[5] = '{0, 1, 2, 3, 0};
        logic [15:0] rr_bcd[5] = '{16'h0042, 16'h0500, 16'h7777, 16'h9000, 16'h0003};

        // Reset state, with all requesters asserted to show req_ready is held low.
        req_valid = 4'b1111;
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_bcd", 32'(rsp_bcd), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        req_valid = '0;
        @(posedge clock);
        #1;
        a_rst = 1'b0;

        // Single conversions and range limits.
        do_single(0, 16'h2649, 16'h9801, 1'b0, 17);
        do_single(1, 16'd10000, 16'h9999, 1'b1, 1);
        do_single(2, 16'd65535, 16'h9999, 1'b1, 1);
        do_single(3, 16'd9999, 16'h9999, 1'b0, 17);
        do_single(0, 16'd0, 16'h0000, 1'b0, 17);

        // All four requesting after reset: order 0,1,2,3,0, 18 cycles apart.
        @(posedge clock);
        #1;
        a_rst = 1'b1;
        @(posedge clock);
        #1;
        a_rst = 1'b0;
        req_bin   = {16'd9000, 16'd7777, 16'd500, 16'd42};
        req_valid = 4'b1111;
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(idx, g);
            check("rr_order", 32'(idx), 32'(order[k]));
            if (k > 0) check("rr_spacing", 32'(g - last), 32'd18);
            last = g;
            exp_q.push_back('{id: 2'(order[k]), bcd: rr_bcd[k], ovf: 1'b0});
            @(posedge clock);
            #1;
            if (k == 0) req_bin[15:0] = 16'd3;
            else req_valid[order[k]] = 1'b0;
        end
        wait_idle();

        // Response stalled 5 cycles while requesters 2 and 3 are pending.
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        req_bin[31:16] = 16'd1234;
        req_valid[1] = 1'b1;
        wait_grant(idx, g);
        check("stall_grant", 32'(idx), 32'd1);
        exp_q.push_back('{id: 2'd1, bcd: 16'h1234, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        req_bin[47:32] = 16'd56;
        req_bin[63:48] = 16'd8;
        req_valid[3:2] = 2'b11;
        wait_rsp(ok);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_bcd", 32'(rsp_bcd), 32'h1234);
            check("stall_id", 32'(rsp_id), 32'd1);
            check("stall_no_grant", 32'(req_ready), 32'd0);
            if (i < 4) @(negedge clock);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("hs_no_grant", 32'(req_ready), 32'd0);
        @(negedge clock);
        check("grant_after_hs", 32'(req_ready), 32'b0100);
        exp_q.push_back('{id: 2'd2, bcd: 16'h0056, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        wait_grant(idx, g);
        check("stall_next_grant", 32'(idx), 32'd3);
        exp_q.push_back('{id: 2'd3, bcd: 16'h0008, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[3] = 1'b0;
        wait_idle();

        // Reset in CONV cycle 8 drops the request; pointer returns to 0.
        @(posedge clock);
        #1;
        req_bin[63:48] = 16'd4321;
        req_valid[3] = 1'b1;
        wait_grant(idx, g);
        check("mid_grant", 32'(idx), 32'd3);
        @(posedge clock);
        #1;
        req_valid[3] = 1'b0;
        req_bin[15:0]  = 16'd8;
        req_bin[47:32] = 16'd6000;
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        repeat (8) @(negedge clock);
        check("mid_in_conv", 32'(busy), 32'd1);
        a_rst = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_rsp_bcd", 32'(rsp_bcd), 32'd0);
        check("mid_rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        a_rst = 1'b0;
        wait_grant(idx, g);
        check("post_rst_grant", 32'(idx), 32'd0);
        exp_q.push_back('{id: 2'd0, bcd: 16'h0008, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        wait_grant(idx, g);
        check("post_rst_grant2", 32'(idx), 32'd2);
        exp_q.push_back('{id: 2'd2, bcd: 16'h6000, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[2] = 1'b0;
        wait_idle();

        // Requester 1 withdraws while requester 3 holds the converter.
        @(posedge clock);
        #1;
        req_bin[31:16] = 16'd77;
        req_bin[63:48] = 16'd255;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        wait_grant(idx, g);
        check("skip_grant", 32'(idx), 32'd3);
        exp_q.push_back('{id: 2'd3, bcd: 16'h0255, ovf: 1'b0});
        @(posedge clock);
        #1;
        req_valid[3] = 1'b0;
        req_valid[1] = 1'b0;
        extra = 0;
        repeat (30) begin
            @(negedge clock);
            if (|(req_valid & req_ready)) extra++;
        end
        check("skip_no_grant", 32'(extra), 32'd0);
        wait_idle();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one sequential 16-bit binary-to-BCD (double-dabble) converter between `N_REQ` requesters. It arbitrates requests, range-checks the operand, sequences the converter through its 16 shift iterations, and returns the packed 4-digit BCD result tagged with the requester ID over a valid/ready response port. It sits between the display/report clients and the conversion datapath.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: requester ID width, equal to `$clog2(N_REQ)`.
- `clock`, in, 1: single clock, rising edge.
- `a_rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, `N_REQ`: per-requester request.
- `req_bin`, in, `16*N_REQ`: operands. Requester i uses bits `[16*i+15:16*i]`.
- `req_ready`, out, `N_REQ`: one-hot grant. A request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`, out, 1: result available.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_id`, out, `ID_W`: index of the granted requester.
- `rsp_bcd`, out, 16: four BCD digits, thousands digit in `[15:12]`.
- `rsp_ovf`, out, 1: operand was greater than 9999.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states:
  - **IDLE**: if any `req_valid` is high, select the winner by round-robin starting at pointer `ptr`. Assert `req_ready[winner]` combinationally in this cycle only. At the clock edge, capture `req_bin` and the ID, then set `ptr` to `(winner+1) mod N_REQ`.
    - Operand ≤ 9999: pulse core `start`, go to CONV.
    - Operand > 9999: load `rsp_bcd=16'h9999` and `rsp_ovf=1`, go to RESP with no conversion.
    - No `req_valid`: stay in IDLE.
  - **CONV**: the core performs one iteration per cycle (add-3 to each digit greater than 4, then shift in the next operand bit, MSB first). Go to RESP on core `done`, after exactly 16 CONV cycles. Load `rsp_bcd` from the core and set `rsp_ovf=0`.
  - **RESP**: hold `rsp_valid=1` and keep `rsp_id`, `rsp_bcd`, `rsp_ovf` stable until `rsp_ready`. At the handshake edge, go to IDLE.
- No grant is issued outside IDLE. A grant never occurs in the same cycle as a response handshake.
- Requesters hold `req_valid` and `req_bin` stable until granted. A requester that deasserts before being granted is skipped with no penalty.
- Arithmetic:
  - The operand is always treated as unsigned 16-bit.
  - Values 0..9999 convert exactly.
  - The comparison against 9999 is done on the full 16-bit operand.
- Reset (any time, including mid-CONV or RESP):
  - State returns to IDLE and `ptr` to 0.
  - The core counter and shift register clear.
  - All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_bcd`, `rsp_ovf`, `busy`.
  - The in-flight request is dropped and no response is produced.

## Timing
- Normal path: grant edge E0. CONV covers cycles 1..16. `rsp_valid` rises after edge E16 and is visible in cycle 17.
- Overflow path: `rsp_valid` is visible in cycle 1 after the grant.
- Minimum spacing between grants is 18 cycles when `rsp_ready` is tied high: 1 IDLE + 16 CONV + 1 RESP.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- `rsp_*` outputs keep their last values after the handshake until the next load.

## Structure
- Shared package `bcd_pkg`:
  - state encoding (IDLE, CONV, RESP);
  - `BCD_DIGITS=4`, `BIN_W=16`, `MAX_DEC=16'd9999`, `BCD_SAT=16'h9999`.
- Sub-module `bcd_dabble_core`:
  - ports: `clock`, `a_rst`, `start`, `bin[15:0]`, `done`, `bcd[15:0]`;
  - 5-bit iteration counter;
  - `done` pulses for one cycle after the 16th iteration;
  - `start` is ignored while the core is running.
- The top level holds the arbiter, FSM, and response registers.

## Test plan
- Requester 0 only, `req_bin=16'h2649` → `rsp_bcd=16'h9801`, `rsp_id=0`, `rsp_ovf=0`, `rsp_valid` in cycle 17 after the grant.
- All four request together after reset, `rsp_ready=1` → grant order 0,1,2,3,0. Grants are 18 cycles apart. Each `rsp_id` matches its own operand.
- Overflow and range limits:
  - `req_bin=16'd10000` → `rsp_bcd=16'h9999`, `rsp_ovf=1`, `rsp_valid` in cycle 1 after the grant.
  - `16'd65535` → same result.
  - `16'd9999` → `16'h9999` with `rsp_ovf=0`.
  - `16'd0` → `16'h0000`.
- `rsp_ready` held low for 5 cycles in RESP while other requests are pending → outputs stay stable, all `req_ready` stay 0, and the next grant occurs in the cycle after the handshake.
- `a_rst` pulsed during CONV cycle 8 → all outputs 0 immediately and no response is produced. Afterwards, with requesters 2 and 0 pending, the next grant goes to requester 0.
- Requester 1 drops `req_valid` while requester 3 is granted → requester 1 is skipped with no response.
